// File: rtl/chan_mux_scan.sv
// chan_mux_scan: registered NCH x WIDTH channel multiplexer.
// mode=0 selects the channel given on sel; mode=1 walks an internal pointer
// over all channels, holding each for DWELL enabled clocks. out, out_sel,
// out_valid and wrap are all registered (one clock of latency).
// out_valid is a plain qualifier, not a handshake: there is no ready, and a
// consumer simply samples out whenever out_valid is high.
module chan_mux_scan #(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int DWELL = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH*WIDTH-1:0]   in_bus,
  input  logic [SELW-1:0]        sel,
  input  logic                   mode,
  input  logic                   en,
  output logic [WIDTH-1:0]       out,
  output logic [SELW-1:0]        out_sel,
  output logic                   out_valid,
  output logic                   wrap
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [SELW-1:0]  r_ptr;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_out;
  logic [SELW-1:0]  r_out_sel;
  logic             r_out_valid;
  logic             r_wrap;
  // High when the previous registered output came from a scan cycle; keeps a
  // manual sel of NCH-1 followed by scan entry from looking like a wrap.
  logic             r_scan_act;

  logic [WIDTH-1:0] w_man_data;
  logic             w_man_ok;
  logic [WIDTH-1:0] w_scan_data;
  logic [SELW-1:0]  w_ptr_nxt;
  logic [CNTW-1:0]  w_cnt_nxt;
  logic             w_cnt_last;
  logic             w_ptr_last;
  logic             w_wrap_nxt;

  assign w_cnt_last = (r_cnt == CNTW'(DWELL - 1));
  assign w_ptr_last = (r_ptr == SELW'(NCH - 1));

  // Channel lookup for both the manual select and the scan pointer; a sel
  // that matches no channel (NCH not a power of 2) yields zero data, not ok.
  always_comb begin
    w_man_data  = '0;
    w_man_ok    = 1'b0;
    w_scan_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) begin
        w_man_data = in_bus[k*WIDTH +: WIDTH];
        w_man_ok   = 1'b1;
      end
      if (r_ptr == SELW'(k)) begin
        w_scan_data = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer / dwell counter advance; both are parked at 0 in manual mode so
  // scan entry always starts at channel 0 with a full dwell.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    if (!mode) begin
      w_ptr_nxt = '0;
      w_cnt_nxt = '0;
    end else if (en) begin
      if (w_cnt_last) begin
        w_cnt_nxt = '0;
        w_ptr_nxt = w_ptr_last ? '0 : r_ptr + SELW'(1);
      end else begin
        w_cnt_nxt = r_cnt + CNTW'(1);
      end
    end
  end

  // Wrap fires on the scan cycle where out_sel moves from NCH-1 back to 0.
  always_comb begin
    w_wrap_nxt = mode && r_scan_act && (r_ptr == '0) &&
                 (r_out_sel == SELW'(NCH - 1));
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_scan_act  <= 1'b0;
    end else begin
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wrap     <= w_wrap_nxt;
      r_scan_act <= mode;
      if (mode) begin
        r_out       <= w_scan_data;
        r_out_sel   <= r_ptr;
        r_out_valid <= 1'b1;
      end else begin
        r_out       <= w_man_data;
        r_out_sel   <= sel;
        r_out_valid <= w_man_ok;
      end
    end
  end

  assign out       = r_out;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_chan_mux_scan.sv
// Bench for chan_mux_scan: three instances (8ch/DWELL4, 5ch/DWELL2,
// 3ch/DWELL1) driven with a directed vector table plus hand sequences.
module tb_chan_mux_scan;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- DUT signals ----------------
  logic [63:0] bus8;  logic [2:0] sel8;  logic mode8, en8;
  logic [7:0]  out8;  logic [2:0] osel8; logic val8, wrap8;

  logic [39:0] bus5;  logic [2:0] sel5;  logic mode5, en5;
  logic [7:0]  out5;  logic [2:0] osel5; logic val5, wrap5;

  logic [11:0] bus1;  logic [1:0] sel1;  logic mode1, en1;
  logic [3:0]  out1;  logic [1:0] osel1; logic val1, wrap1;

  chan_mux_scan #(.WIDTH(8), .NCH(8), .DWELL(4)) dut8 (
    .clk(clk), .reset(reset), .in_bus(bus8), .sel(sel8), .mode(mode8),
    .en(en8), .out(out8), .out_sel(osel8), .out_valid(val8), .wrap(wrap8));

  chan_mux_scan #(.WIDTH(8), .NCH(5), .DWELL(2)) dut5 (
    .clk(clk), .reset(reset), .in_bus(bus5), .sel(sel5), .mode(mode5),
    .en(en5), .out(out5), .out_sel(osel5), .out_valid(val5), .wrap(wrap5));

  chan_mux_scan #(.WIDTH(4), .NCH(3), .DWELL(1)) dut1 (
    .clk(clk), .reset(reset), .in_bus(bus1), .sel(sel1), .mode(mode1),
    .en(en1), .out(out1), .out_sel(osel1), .out_valid(val1), .wrap(wrap1));

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] eo,
                        input logic [2:0] es, input logic ev, input logic ew);
    check({tag, ".out"},   32'(out8),  32'(eo));
    check({tag, ".sel"},   32'(osel8), 32'(es));
    check({tag, ".valid"}, 32'(val8),  32'(ev));
    check({tag, ".wrap"},  32'(wrap8), 32'(ew));
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic       en;
    logic [7:0] e_out;
    logic [2:0] e_sel;
    logic       e_valid;
    logic       e_wrap;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int es;
    // Manual sweep: channel k holds 8'h10+k.
    for (int k = 0; k < 8; k++)
      tbl[k] = '{1'b0, 3'(k), 1'b0, 8'(8'h10 + k), 3'(k), 1'b1, 1'b0};
    // Enter scan straight after sel=7: channel 0, no wrap.
    tbl[8]  = '{1'b1, 3'd7, 1'b1, 8'h10, 3'd0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 3'd7, 1'b1, 8'h10, 3'd0, 1'b1, 1'b0};
    // Drop back to manual mid-dwell.
    tbl[10] = '{1'b0, 3'd5, 1'b1, 8'h15, 3'd5, 1'b1, 1'b0};
    // Re-enter scan: full dwell of 4 on channel 0 again, then channel 1.
    tbl[11] = '{1'b1, 3'd5, 1'b1, 8'h10, 3'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 3'd5, 1'b1, 8'h10, 3'd0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 3'd5, 1'b1, 8'h10, 3'd0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 3'd5, 1'b1, 8'h10, 3'd0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 3'd5, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0};

    for (int k = 0; k < 8; k++) bus8[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < 5; k++) bus5[k*8 +: 8] = 8'(8'hA0 + k);
    bus1 = 12'hCBA;

    // ---- reset with arbitrary inputs ----
    reset = 1'b1;
    mode8 = 1'b1; sel8 = 3'd3; en8 = 1'b1;
    mode5 = 1'b1; sel5 = 3'd6; en5 = 1'b1;
    mode1 = 1'b1; sel1 = 2'd2; en1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check8($sformatf("reset%0d", i), 8'h00, 3'd0, 1'b0, 1'b0);
      check($sformatf("reset%0d.out5", i), 32'(out5), 32'h0);
      check($sformatf("reset%0d.valid5", i), 32'(val5), 32'h0);
      check($sformatf("reset%0d.sel1", i), 32'(osel1), 32'h0);
    end
    reset = 1'b0;
    mode5 = 1'b0; mode1 = 1'b0; en5 = 1'b0; en1 = 1'b0;

    // ---- table: manual sweep and mode toggling ----
    for (int i = 0; i < 16; i++) begin
      mode8 = tbl[i].mode; sel8 = tbl[i].sel; en8 = tbl[i].en;
      tick();
      check8($sformatf("tbl%0d", i), tbl[i].e_out, tbl[i].e_sel,
             tbl[i].e_valid, tbl[i].e_wrap);
    end

    // ---- full scan from reset, live data on channel 3 ----
    reset = 1'b1; mode8 = 1'b1; en8 = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      if (c == 14) bus8[31:24] = 8'h5A;
      if (c == 16) bus8[31:24] = 8'h13;
      tick();
      es = ((c - 1) / 4) % 8;
      check8($sformatf("scan_c%0d", c), bus8[es*8 +: 8], 3'(es), 1'b1,
             (c == 33));
      if (c == 14) check("scan_ch3_live", 32'(out8), 32'h5A);
    end

    // ---- reset mid-scan while out_sel=5, then restart ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 21; c++) tick();
    check("pre_reset_sel", 32'(osel8), 32'd5);
    reset = 1'b1;
    tick();
    check8("midscan_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      es = (c <= 4) ? 0 : 1;
      check8($sformatf("restart_c%0d", c), bus8[es*8 +: 8], 3'(es), 1'b1,
             1'b0);
    end

    // ---- enable gating: en low 5 cycles mid-dwell on channel 2 ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      en8 = (c >= 11 && c <= 15) ? 1'b0 : 1'b1;
      tick();
      if (c <= 8)       es = (c - 1) / 4;
      else if (c <= 17) es = 2;
      else              es = 3;
      check8($sformatf("gate_c%0d", c), bus8[es*8 +: 8], 3'(es), 1'b1, 1'b0);
    end
    mode8 = 1'b0; en8 = 1'b1;

    // ---- NCH=5: out-of-range select and scan wrap ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mode5 = 1'b0; sel5 = 3'd6;
    tick();
    check("n5_sel6.out", 32'(out5), 32'h0);
    check("n5_sel6.valid", 32'(val5), 32'h0);
    check("n5_sel6.sel", 32'(osel5), 32'd6);
    sel5 = 3'd4;
    tick();
    check("n5_sel4.out", 32'(out5), 32'hA4);
    check("n5_sel4.valid", 32'(val5), 32'h1);
    sel5 = 3'd5;
    tick();
    check("n5_sel5.valid", 32'(val5), 32'h0);
    check("n5_sel5.out", 32'(out5), 32'h0);
    mode5 = 1'b1; en5 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      es = ((c - 1) / 2) % 5;
      check($sformatf("n5_scan_c%0d.sel", c), 32'(osel5), 32'(es));
      check($sformatf("n5_scan_c%0d.out", c), 32'(out5), 32'(8'hA0 + es));
      check($sformatf("n5_scan_c%0d.wrap", c), 32'(wrap5), 32'(c == 11));
    end
    mode5 = 1'b0;

    // ---- DWELL=1: pointer advances every enabled edge ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mode1 = 1'b1; en1 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      es = (c - 1) % 3;
      check($sformatf("d1_c%0d.sel", c), 32'(osel1), 32'(es));
      check($sformatf("d1_c%0d.out", c), 32'(out1), 32'(4'hA + es));
      check($sformatf("d1_c%0d.wrap", c), 32'(wrap1),
            32'(c == 4 || c == 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
